reg_file_scoreboard: RTL and testbench

//  Parametrised successor register file for the pipelined core: two async read ports, one sync write port.

---
 rtl/reg_file_scoreboard.sv | 151 +++++++++++++++
 tb/tb_reg_file_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
//
// Register file for the pipelined core with a pending-write scoreboard.
// Two combinational read ports, one synchronous write port, optional
// same-cycle write-to-read bypass, optional hardwired zero register and a
// sequencer that clears every entry after reset before the file is usable.
// Decode uses the busy bits to detect RAW hazards on registers whose
// producing instruction has issued but not yet written back.
//
// Ports
//   clk           clock, all state updates on posedge
//   reset_i       asynchronous active-high reset
//   rs_addr_i     read port A address      rs_val_o   read port A data
//   rd_addr_i     read port B address      rd_val_o   read port B data
//   wen_i         write enable (writeback)
//   wa_i          write address            write_data_i  write data
//   set_busy_i    mark set_addr_i pending  set_addr_i    destination register
//   rs_busy_o     busy bit of rs_addr_i    rd_busy_o     busy bit of rd_addr_i
//   init_done_o   high once the clearing sequence has finished
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 6,
    parameter int zero_reg_p   = 1,
    parameter int bypass_p     = 1
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] rs_addr_i,
    input  logic [addr_width_p-1:0] rd_addr_i,
    output logic [data_width_p-1:0] rs_val_o,
    output logic [data_width_p-1:0] rd_val_o,
    input  logic                    wen_i,
    input  logic [addr_width_p-1:0] wa_i,
    input  logic [data_width_p-1:0] write_data_i,
    input  logic                    set_busy_i,
    input  logic [addr_width_p-1:0] set_addr_i,
    output logic                    rs_busy_o,
    output logic                    rd_busy_o,
    output logic                    init_done_o
);

    localparam int DEPTH = 2 ** addr_width_p;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [addr_width_p-1:0] clr_ptr_q, clr_ptr_d;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [data_width_p-1:0] rf_q [DEPTH];

    logic ready;
    logic wr_en;
    logic set_en;
    logic zero_on;
    logic bypass_on;

    assign ready     = (state_q == READY);
    assign zero_on   = (zero_reg_p != 0);
    assign bypass_on = (bypass_p != 0);

    // A write or busy-set to register 0 is dropped entirely when the zero
    // register is hardwired, so it can neither change data nor be bypassed.
    assign wr_en  = ready && wen_i && !(zero_on && (wa_i == '0));
    assign set_en = ready && set_busy_i && !(zero_on && (set_addr_i == '0));

    // Clearing sequencer: walks clr_ptr across the whole array once, then
    // parks in READY until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (&clr_ptr_q) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Scoreboard update. The set is applied after the writeback clear so an
    // instruction issuing to the same destination keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wa_i] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Storage array has no reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            rf_q[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            rf_q[wa_i] <= write_data_i;
        end
    end

    // Read ports: zero while clearing, zero for a hardwired register 0,
    // otherwise the stored value or the in-flight write when bypassing.
    always_comb begin
        rs_val_o = '0;
        if (ready && !(zero_on && (rs_addr_i == '0))) begin
            if (bypass_on && wr_en && (wa_i == rs_addr_i)) begin
                rs_val_o = write_data_i;
            end else begin
                rs_val_o = rf_q[rs_addr_i];
            end
        end
    end

    always_comb begin
        rd_val_o = '0;
        if (ready && !(zero_on && (rd_addr_i == '0))) begin
            if (bypass_on && wr_en && (wa_i == rd_addr_i)) begin
                rd_val_o = write_data_i;
            end else begin
                rd_val_o = rf_q[rd_addr_i];
            end
        end
    end

    // Busy outputs reflect registered state only; no same-cycle forwarding.
    assign rs_busy_o = ready && busy_q[rs_addr_i] && !(zero_on && (rs_addr_i == '0));
    assign rd_busy_o = ready && busy_q[rd_addr_i] && !(zero_on && (rd_addr_i == '0));

    assign init_done_o = ready;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_file_scoreboard
//
// Drives two register files side by side from the same inputs, one with
// bypass and one without, both 8 entries deep with a hardwired register 0.
// A behavioural model of the register contents, busy set and init status
// predicts every output.
// ---------------------------------------------------------------------------
module tb_reg_file_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset_i;
    logic [AW-1:0] rs_addr_i;
    logic [AW-1:0] rd_addr_i;
    logic          wen_i;
    logic [AW-1:0] wa_i;
    logic [DW-1:0] write_data_i;
    logic          set_busy_i;
    logic [AW-1:0] set_addr_i;

    logic [DW-1:0] rsValBp, rdValBp, rsValNb, rdValNb;
    logic          rsBusyBp, rdBusyBp, rsBusyNb, rdBusyNb;
    logic          initDoneBp, initDoneNb;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: plain arrays for contents and pending writes, plus a
    // count of clearing cycles seen since the last reset release.
    logic [DW-1:0] modelRf [DEPTH];
    bit            modelBusy [DEPTH];
    bit            modelReady;
    int            clrCount;

    reg_file_scoreboard #(
        .data_width_p(DW), .addr_width_p(AW), .zero_reg_p(1), .bypass_p(1)
    ) dutBp (
        .clk(clk), .reset_i(reset_i),
        .rs_addr_i(rs_addr_i), .rd_addr_i(rd_addr_i),
        .rs_val_o(rsValBp), .rd_val_o(rdValBp),
        .wen_i(wen_i), .wa_i(wa_i), .write_data_i(write_data_i),
        .set_busy_i(set_busy_i), .set_addr_i(set_addr_i),
        .rs_busy_o(rsBusyBp), .rd_busy_o(rdBusyBp),
        .init_done_o(initDoneBp)
    );

    reg_file_scoreboard #(
        .data_width_p(DW), .addr_width_p(AW), .zero_reg_p(1), .bypass_p(0)
    ) dutNb (
        .clk(clk), .reset_i(reset_i),
        .rs_addr_i(rs_addr_i), .rd_addr_i(rd_addr_i),
        .rs_val_o(rsValNb), .rd_val_o(rdValNb),
        .wen_i(wen_i), .wa_i(wa_i), .write_data_i(write_data_i),
        .set_busy_i(set_busy_i), .set_addr_i(set_addr_i),
        .rs_busy_o(rsBusyNb), .rd_busy_o(rdBusyNb),
        .init_done_o(initDoneNb)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and counts the pass or reports the failure.
    task automatic checkVal(input string tag, input logic [DW-1:0] observed,
                            input logic [DW-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Expected read data: nothing visible until clearing is done, register 0
    // always zero, and a live write shows through only on the bypass build.
    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a, input bit bp);
        if (!modelReady || a == 0) return '0;
        if (bp && wen_i && wa_i == a) return write_data_i;
        return modelRf[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        return modelReady && (a != 0) && modelBusy[a];
    endfunction

    // Reset clears the pending set and restarts the clearing count.
    task automatic modelReset();
        modelReady = 0;
        clrCount   = 0;
        for (int i = 0; i < DEPTH; i++) modelBusy[i] = 0;
    endtask

    // What one rising edge does to the model, given the inputs held over it.
    task automatic modelEdge();
        if (reset_i) begin
            modelReset();
        end else if (!modelReady) begin
            clrCount++;
            if (clrCount == DEPTH) begin
                modelReady = 1;
                for (int i = 0; i < DEPTH; i++) modelRf[i] = '0;
            end
        end else begin
            if (wen_i && wa_i != 0) begin
                modelRf[wa_i]   = write_data_i;
                modelBusy[wa_i] = 0;
            end
            if (set_busy_i && set_addr_i != 0) modelBusy[set_addr_i] = 1;
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] data, input logic sb,
                                 input logic [AW-1:0] sa, input logic [AW-1:0] rs,
                                 input logic [AW-1:0] rd);
        wen_i        = wen;
        wa_i         = wa;
        write_data_i = data;
        set_busy_i   = sb;
        set_addr_i   = sa;
        rs_addr_i    = rs;
        rd_addr_i    = rd;
    endtask

    // Compares every output of both instances against the model.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".rsValBp"},  rsValBp,    expRead(rs_addr_i, 1));
        checkVal({tag, ".rdValBp"},  rdValBp,    expRead(rd_addr_i, 1));
        checkVal({tag, ".rsValNb"},  rsValNb,    expRead(rs_addr_i, 0));
        checkVal({tag, ".rdValNb"},  rdValNb,    expRead(rd_addr_i, 0));
        checkVal({tag, ".rsBusyBp"}, 32'(rsBusyBp), 32'(expBusy(rs_addr_i)));
        checkVal({tag, ".rdBusyBp"}, 32'(rdBusyBp), 32'(expBusy(rd_addr_i)));
        checkVal({tag, ".rsBusyNb"}, 32'(rsBusyNb), 32'(expBusy(rs_addr_i)));
        checkVal({tag, ".rdBusyNb"}, 32'(rdBusyNb), 32'(expBusy(rd_addr_i)));
        checkVal({tag, ".initBp"},   32'(initDoneBp), 32'(modelReady));
        checkVal({tag, ".initNb"},   32'(initDoneNb), 32'(modelReady));
    endtask

    // Check mid-cycle, let the edge happen, advance the model, then step
    // just past the edge so the next inputs change away from it.
    task automatic runCycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic randomCycle(input string tag);
        applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
                      $urandom, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DEPTH-1)),
                      AW'($urandom_range(0, DEPTH-1)),
                      AW'($urandom_range(0, DEPTH-1)));
        runCycle(tag);
    endtask

    // Directed sequence interleaved with randomized traffic.
    initial begin
        reset_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #2;
        checkOutput("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Three clear cycles with random traffic, then reset mid-clear.
        for (int i = 0; i < 3; i++) randomCycle("clearA");
        reset_i = 1'b1;
        #1;
        modelReset();
        checkOutput("midClearReset");
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Full eight-cycle clear repeats; outputs stay zero throughout.
        for (int i = 0; i < DEPTH; i++) randomCycle("clearB");
        applyStimulus(0, 0, 0, 0, 0, 3, 6);
        #1;
        checkVal("initDone9th", 32'(initDoneBp), 32'd1);
        runCycle("firstReady");

        // Same-cycle write to reg 5 read back on port A.
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        #1;
        checkVal("bypassNow",  rsValBp, 32'hDEADBEEF);
        checkVal("noBypassNow", rsValNb, 32'h0);
        runCycle("bypass");
        applyStimulus(0, 0, 0, 0, 0, 5, 2);
        #1;
        checkVal("bypassNext",  rsValBp, 32'hDEADBEEF);
        checkVal("noBypassNext", rsValNb, 32'hDEADBEEF);
        runCycle("afterBypass");

        // Register 0 ignores writes and busy marking.
        applyStimulus(1, 0, 32'h00001234, 1, 0, 0, 0);
        runCycle("zeroWrite");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkVal("zeroVal",  rsValBp, 32'h0);
        checkVal("zeroBusy", 32'(rsBusyBp), 32'd0);
        runCycle("zeroRead");

        // Busy on reg 7, then writeback and re-issue to reg 7 together.
        applyStimulus(0, 0, 0, 1, 7, 0, 7);
        runCycle("setBusy7");
        applyStimulus(0, 0, 0, 0, 0, 0, 7);
        #1;
        checkVal("busy7", 32'(rdBusyBp), 32'd1);
        runCycle("busy7Read");
        applyStimulus(1, 7, 32'hCAFEF00D, 1, 7, 0, 7);
        runCycle("setWinsWrite");
        applyStimulus(0, 0, 0, 0, 0, 0, 7);
        #1;
        checkVal("busy7Kept", 32'(rdBusyBp), 32'd1);
        checkVal("rf7Written", rdValNb, 32'hCAFEF00D);
        runCycle("setWinsRead");

        // Writeback alone retires the pending write on reg 7.
        applyStimulus(1, 7, 32'h0BADF00D, 0, 0, 0, 7);
        runCycle("clear7");
        applyStimulus(0, 0, 0, 0, 0, 0, 7);
        #1;
        checkVal("busy7Cleared", 32'(rdBusyBp), 32'd0);
        runCycle("clear7Read");

        for (int i = 0; i < 300; i++) randomCycle("random");

        // Reset while READY drops init_done without waiting for an edge.
        reset_i = 1'b1;
        #1;
        modelReset();
        checkVal("initDrop", 32'(initDoneBp), 32'd0);
        checkOutput("readyReset");
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 2; i++) randomCycle("postReset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
